// File: rtl/ro_puf_pkg.sv
// Shared definitions for the ring-oscillator PUF measurement sequencer.
// Provides the sequencer FSM state type, default parameter values and a helper
// that extracts one challenge pair (ring A index in the low half, ring B index
// in the high half) from the packed challenge vector.
package ro_puf_pkg;

  localparam int unsigned NumRoDef    = 8;
  localparam int unsigned RespBitsDef = 4;
  localparam int unsigned WindowDef   = 1024;
  localparam int unsigned SettleDef   = 4;
  localparam int unsigned CntWDef     = 16;
  localparam int unsigned MarginDef   = 4;

  // Widest packed challenge the slice helper accepts.
  localparam int unsigned MaxChalW = 256;

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StCount,
    StDrain,
    StCompare,
    StDone
  } state_e;

  // Returns pair k of the challenge as {idx_b, idx_a} in the low 2*idx_w bits.
  function automatic logic [31:0] chal_slice(input logic [MaxChalW-1:0] chal,
                                             input int unsigned        k,
                                             input int unsigned        idx_w);
    return 32'(chal >> (2 * idx_w * k)) & ((32'd1 << (2 * idx_w)) - 32'd1);
  endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// Rising-edge counter for one asynchronous ring-oscillator output.
// Ports:
//   clk_i       system clock
//   rst_i       synchronous active-high reset
//   clear_i     zero the count (takes priority over counting)
//   count_en_i  count sampled rising edges while high
//   ro_i        raw ring output, asynchronous to clk_i
//   cnt_o       saturating edge count
module ro_edge_counter
  import ro_puf_pkg::*;
#(
  parameter int unsigned CNT_W = CntWDef
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             count_en_i,
  input  logic             ro_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic             sync1_q, sync2_q, prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise;

  assign rise = sync2_q & ~prev_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_en_i && rise && (cnt_q != '1)) begin
      // Hold at all-ones so a fast ring can never wrap to a small count.
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= ro_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cnt_q   <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ro_puf_ctrl.sv
// Measurement sequencer for the ring-oscillator PUF array. For each of
// RESP_BITS challenge pairs it enables two rings, lets them settle, counts their
// edges for WINDOW cycles, drains the synchronizers and compares the counts
// into one response bit. Optional feature macro RO_PUF_MARGIN_EN adds the
// unstable output flagging pairs whose counts differ by less than MARGIN.
// Ports:
//   clk_i        system clock
//   rst_i        synchronous active-high reset
//   start_i      begin a run (sampled only when idle)
//   challenge_i  packed pairs, pair k = [2*IDX_W*k +: 2*IDX_W], ring A low
//   ro_out_i     raw ring outputs
//   ro_enable_o  registered ring enables
//   busy_o       run in progress
//   done_o       one-cycle pulse, response valid
//   response_o   bit k = (count A > count B) for pair k
//   unstable_o   bit k = counts of pair k closer than MARGIN (macro only)
module ro_puf_ctrl
  import ro_puf_pkg::*;
#(
  parameter int unsigned NUM_RO    = NumRoDef,
  parameter int unsigned RESP_BITS = RespBitsDef,
  parameter int unsigned WINDOW    = WindowDef,
  parameter int unsigned SETTLE    = SettleDef,
  parameter int unsigned CNT_W     = CntWDef,
  parameter int unsigned MARGIN    = MarginDef
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   start_i,
  input  logic [RESP_BITS*2*$clog2(NUM_RO)-1:0]  challenge_i,
  input  logic [NUM_RO-1:0]                      ro_out_i,
  output logic [NUM_RO-1:0]                      ro_enable_o,
  output logic                                   busy_o,
  output logic                                   done_o,
`ifdef RO_PUF_MARGIN_EN
  output logic [RESP_BITS-1:0]                   response_o,
  output logic [RESP_BITS-1:0]                   unstable_o
`else
  output logic [RESP_BITS-1:0]                   response_o
`endif
);

  localparam int unsigned IDX_W  = $clog2(NUM_RO);
  localparam int unsigned PAIR_W = 2 * IDX_W;
  localparam int unsigned CHAL_W = RESP_BITS * PAIR_W;
  localparam int unsigned K_W    = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam int unsigned TMR_W  = $clog2(WINDOW + SETTLE + 1);

  state_e              state_q, state_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [K_W-1:0]      k_q, k_d;
  logic [CHAL_W-1:0]   chal_q, chal_d;
  logic [NUM_RO-1:0]   ro_enable_q, ro_enable_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [RESP_BITS-1:0] response_q, response_d;

  logic [PAIR_W-1:0]   pair;
  logic [IDX_W-1:0]    idx_a, idx_b;
  logic                a_valid, b_valid;
  logic                ro_a, ro_b;
  logic [CNT_W-1:0]    cnt_a, cnt_b;

  assign pair    = PAIR_W'(chal_slice(MaxChalW'(chal_q), 32'(k_q), IDX_W));
  assign idx_a   = pair[IDX_W-1:0];
  assign idx_b   = pair[PAIR_W-1:IDX_W];
  // Out-of-range indices select no ring and therefore count nothing.
  assign a_valid = 32'(idx_a) < NUM_RO;
  assign b_valid = 32'(idx_b) < NUM_RO;
  assign ro_a    = a_valid & ro_out_i[idx_a];
  assign ro_b    = b_valid & ro_out_i[idx_b];

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear_i    (state_q == StSettle),
    .count_en_i (state_q == StCount),
    .ro_i       (ro_a),
    .cnt_o      (cnt_a)
  );

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear_i    (state_q == StSettle),
    .count_en_i (state_q == StCount),
    .ro_i       (ro_b),
    .cnt_o      (cnt_b)
  );

`ifdef RO_PUF_MARGIN_EN
  logic [RESP_BITS-1:0] unstable_q, unstable_d;
  logic [CNT_W-1:0]     cnt_diff;
  assign cnt_diff = (cnt_a > cnt_b) ? (cnt_a - cnt_b) : (cnt_b - cnt_a);
`endif

  // Next-state logic: phase timer counts down to zero, then the phase advances.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    k_d     = k_q;
    chal_d  = chal_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StSettle;
          tmr_d   = TMR_W'(SETTLE - 1);
          k_d     = '0;
          chal_d  = challenge_i;
        end
      end
      StSettle: begin
        if (tmr_q == '0) begin
          state_d = StCount;
          tmr_d   = TMR_W'(WINDOW - 1);
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      StCount: begin
        if (tmr_q == '0) begin
          state_d = StDrain;
          tmr_d   = TMR_W'(1);
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      StDrain: begin
        if (tmr_q == '0) begin
          state_d = StCompare;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      StCompare: begin
        if (32'(k_q) == RESP_BITS - 1) begin
          state_d = StDone;
        end else begin
          state_d = StSettle;
          tmr_d   = TMR_W'(SETTLE - 1);
          k_d     = k_q + K_W'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic: every output is registered from the current state, so it
  // lags the state by one edge.
  always_comb begin
    ro_enable_d = '0;
    busy_d      = (state_q != StIdle);
    done_d      = (state_q == StDone);
    response_d  = response_q;
`ifdef RO_PUF_MARGIN_EN
    unstable_d  = unstable_q;
`endif
    if (state_q == StIdle && start_i) begin
      response_d = '0;
`ifdef RO_PUF_MARGIN_EN
      unstable_d = '0;
`endif
    end
    if (state_q == StSettle || state_q == StCount) begin
      if (a_valid) ro_enable_d[idx_a] = 1'b1;
      if (b_valid) ro_enable_d[idx_b] = 1'b1;
    end
    if (state_q == StCompare) begin
      response_d[k_q] = (cnt_a > cnt_b);
`ifdef RO_PUF_MARGIN_EN
      unstable_d[k_q] = (32'(cnt_diff) < MARGIN);
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      tmr_q       <= '0;
      k_q         <= '0;
      chal_q      <= '0;
      ro_enable_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      response_q  <= '0;
`ifdef RO_PUF_MARGIN_EN
      unstable_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      k_q         <= k_d;
      chal_q      <= chal_d;
      ro_enable_q <= ro_enable_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      response_q  <= response_d;
`ifdef RO_PUF_MARGIN_EN
      unstable_q  <= unstable_d;
`endif
    end
  end

  assign ro_enable_o = ro_enable_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign response_o  = response_q;
`ifdef RO_PUF_MARGIN_EN
  assign unstable_o  = unstable_q;
`endif

endmodule

// File: tb/tb_ro_puf_ctrl.sv
// Bench for ro_puf_ctrl. Each behavioural ring replays a 64-cycle waveform
// holding a known number of rising edges, so a full window sees exactly that
// many edges; expected bits follow from comparing those edge counts.
module tb_ro_puf_ctrl;

  localparam int NR = 8;
  localparam int RB = 4;
  localparam int W  = 64;
  localparam int S  = 4;
  localparam int L  = S + W + 3;
  localparam int IW = 3;
  localparam int CW = RB * 2 * IW;

  logic          clk    = 1'b0;
  logic          rst    = 1'b1;
  logic          start0 = 1'b0;
  logic          start1 = 1'b0;
  logic [CW-1:0] chal   = '0;
  logic [NR-1:0] ro0    = '0;
  logic [NR-1:0] ro1    = '0;
  logic [NR-1:0] en0, en1;
  logic          busy0, done0, busy1, done1;
  logic [RB-1:0] resp0, resp1;
`ifdef RO_PUF_MARGIN_EN
  logic [RB-1:0] unst0, unst1;
`endif

  int          ring_n [NR];
  logic [63:0] pat    [NR];
  logic [5:0]  t0     [NR] = '{default: '0};
  logic [5:0]  t1     [NR] = '{default: '0};
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  ro_puf_ctrl #(.NUM_RO(NR), .RESP_BITS(RB), .WINDOW(W), .SETTLE(S), .CNT_W(16), .MARGIN(4))
  u_dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start0),
    .challenge_i (chal),
    .ro_out_i    (ro0),
    .ro_enable_o (en0),
    .busy_o      (busy0),
    .done_o      (done0),
`ifdef RO_PUF_MARGIN_EN
    .response_o  (resp0),
    .unstable_o  (unst0)
`else
    .response_o  (resp0)
`endif
  );

  ro_puf_ctrl #(.NUM_RO(NR), .RESP_BITS(RB), .WINDOW(W), .SETTLE(S), .CNT_W(4), .MARGIN(4))
  u_dut_sat (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start1),
    .challenge_i (chal),
    .ro_out_i    (ro1),
    .ro_enable_o (en1),
    .busy_o      (busy1),
    .done_o      (done1),
`ifdef RO_PUF_MARGIN_EN
    .response_o  (resp1),
    .unstable_o  (unst1)
`else
    .response_o  (resp1)
`endif
  );

  // Rings restart their waveform on every enable and idle low when disabled.
  always @(negedge clk) begin
    for (int i = 0; i < NR; i++) begin
      if (en0[i] !== 1'b1) begin
        t0[i]  <= '0;
        ro0[i] <= 1'b0;
      end else begin
        ro0[i] <= pat[i][t0[i]];
        t0[i]  <= t0[i] + 6'd1;
      end
      if (en1[i] !== 1'b1) begin
        t1[i]  <= '0;
        ro1[i] <= 1'b0;
      end else begin
        ro1[i] <= pat[i][t1[i]];
        t1[i]  <= t1[i] + 6'd1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // n one-cycle pulses, all clear of the waveform's first and last cycles.
  function automatic logic [63:0] make_pat(input int n);
    logic [63:0] p;
    p = '0;
    for (int j = 0; j < n; j++) p[2 + 2 * j] = 1'b1;
    return p;
  endfunction

  task automatic load_rings();
    for (int i = 0; i < NR; i++) pat[i] = make_pat(ring_n[i]);
  endtask

  function automatic int eff(input int idx, input int sat);
    return (ring_n[idx] > sat) ? sat : ring_n[idx];
  endfunction

  function automatic int idx_of(input logic [CW-1:0] c, input int k, input int side);
    return int'(c[2 * IW * k + IW * side +: IW]);
  endfunction

  function automatic logic [CW-1:0] pack_chal(input int a0, input int b0, input int a1,
                                              input int b1, input int a2, input int b2,
                                              input int a3, input int b3);
    return {3'(b3), 3'(a3), 3'(b2), 3'(a2), 3'(b1), 3'(a1), 3'(b0), 3'(a0)};
  endfunction

  // One run on DUT sel (0: 16-bit counters, 1: 4-bit counters). Edge 0 is the
  // start-accepting edge; outputs are sampled at the falling edge after edge n.
  task automatic run(input int sel, input logic [CW-1:0] c, input bit extra, input int rst_at);
    int            sat, first, ndone, a, b, da, db, k;
    logic [RB-1:0] er, eu;
    logic [NR-1:0] m, en;
    logic          busy, done;
    logic [RB-1:0] resp;
    sat = (sel == 1) ? 15 : 65535;
    er  = '0;
    eu  = '0;
    for (int kk = 0; kk < RB; kk++) begin
      da     = eff(idx_of(c, kk, 0), sat);
      db     = eff(idx_of(c, kk, 1), sat);
      er[kk] = (da > db);
      eu[kk] = ((da > db) ? (da - db) : (db - da)) < 4;
    end
    first = -1;
    ndone = 0;
    @(negedge clk);
    chal = c;
    if (sel == 1) start1 = 1'b1;
    else          start0 = 1'b1;
    @(posedge clk);
    for (int n = 0; n <= 4 * L + 5; n++) begin
      @(negedge clk);
      if (n == 0) begin
        start0 = 1'b0;
        start1 = 1'b0;
      end
      if (extra && n == 99) begin
        start0 = 1'b1;
        chal   = ~c;
      end
      if (extra && n == 100) start0 = 1'b0;
      en   = (sel == 1) ? en1 : en0;
      busy = (sel == 1) ? busy1 : busy0;
      done = (sel == 1) ? done1 : done0;
      resp = (sel == 1) ? resp1 : resp0;
      if (done === 1'b1) begin
        ndone++;
        if (first < 0) first = n;
      end
      if (n == 1) chk("busy_rise", 32'(busy), 32'd1);
      if (n < 4 * L && (n % L == 30 || n % L == 70)) begin
        k = n / L;
        m = '0;
        if (n % L == 30) begin
          a    = idx_of(c, k, 0);
          b    = idx_of(c, k, 1);
          m[a] = 1'b1;
          m[b] = 1'b1;
        end
        chk("ro_enable", 32'(en), 32'(m));
      end
      if (n == 4 * L + 1) begin
        chk("response", 32'(resp), 32'(er));
`ifdef RO_PUF_MARGIN_EN
        chk("unstable", 32'((sel == 1) ? unst1 : unst0), 32'(eu));
`endif
      end
      if (n == 4 * L + 2) begin
        chk("busy_fall", 32'(busy), 32'd0);
        chk("done_fall", 32'(done), 32'd0);
      end
      if (rst_at > 0 && n == rst_at - 1) rst = 1'b1;
      if (rst_at > 0 && n == rst_at) begin
        chk("rst_mid_en", 32'(en), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        chk("rst_mid_resp", 32'(resp), 32'd0);
        rst = 1'b0;
        return;
      end
    end
    chk("done_cycle", 32'(first), 32'(4 * L + 1));
    chk("done_count", 32'(ndone), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      ring_n[i] = 0;
      pat[i]    = '0;
    end

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_en", 32'(en0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_resp", 32'(resp0), 32'd0);
    chk("rst_en_sat", 32'(en1), 32'd0);
`ifdef RO_PUF_MARGIN_EN
    chk("rst_unstable", 32'(unst0), 32'd0);
`endif
    rst = 1'b0;

    // Basic run: rings roughly at half-periods 2, 3, 4, 5.
    ring_n = '{16, 11, 8, 6, 0, 0, 0, 0};
    load_rings();
    run(0, pack_chal(0, 1, 1, 0, 2, 2, 3, 2), 1'b0, 0);
    chk("basic_resp", 32'(resp0), 32'b0001);

    // Second start while busy must be ignored.
    run(0, pack_chal(0, 1, 1, 0, 2, 2, 3, 2), 1'b1, 0);

    // Reset during counting, then a full clean run.
    run(0, pack_chal(0, 1, 1, 0, 2, 2, 3, 2), 1'b0, 40);
    run(0, pack_chal(3, 0, 0, 3, 1, 2, 2, 1), 1'b0, 0);

    // Close and distant count pairs plus a same-ring pair.
    ring_n[4] = 16;
    ring_n[5] = 14;
    ring_n[6] = 10;
    load_rings();
    run(0, pack_chal(4, 5, 4, 6, 2, 2, 5, 4), 1'b0, 0);
    chk("margin_resp", 32'(resp0), 32'b0011);
`ifdef RO_PUF_MARGIN_EN
    chk("margin_unstable", 32'(unst0), 32'b1101);
`endif

    repeat (4) begin
      for (int i = 0; i < NR; i++) ring_n[i] = int'($urandom_range(0, 30));
      load_rings();
      run(0, CW'($urandom), 1'b0, 0);
    end

    // 4-bit counters: 30 and 20 edges both pin at 15 and tie.
    ring_n = '{30, 20, 2, 30, 0, 0, 0, 0};
    load_rings();
    run(1, pack_chal(0, 1, 1, 0, 0, 2, 2, 3), 1'b0, 0);
    chk("sat_resp", 32'(resp1), 32'b0100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
